// File: rtl/stream_serializer.sv
// stream_serializer: splits each IN_WIDTH word into IN_WIDTH/OUT_WIDTH narrow beats,
// with valid/ready handshakes on both the wide input and the narrow output.
module stream_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stream0_valid,
    output logic                 stream0_ready,
    input  logic [IN_WIDTH-1:0]  stream0_data,
    output logic                 stream1_valid,
    input  logic                 stream1_ready,
    output logic [OUT_WIDTH-1:0] stream1_data,
    output logic                 stream1_last,
    output logic                 busy
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int BW = $clog2(RATIO);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [IN_WIDTH-1:0] shreg_q, shreg_d;
    logic                accept;

    assign stream0_ready = state_q == IDLE || (stream1_ready && beat_q == LAST_BEAT);
    assign accept        = stream0_valid && stream0_ready;
    assign stream1_valid = state_q == SEND;
    assign stream1_last  = state_q == SEND && beat_q == LAST_BEAT;
    assign busy          = stream1_valid;
    // The outgoing slice always sits at the end of the shift register nearest the send side
    assign stream1_data  = MSB_FIRST ? shreg_q[IN_WIDTH-1 -: OUT_WIDTH] : shreg_q[OUT_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        shreg_d = shreg_q;
        if (accept) begin
            state_d = SEND;
            beat_d  = '0;
            shreg_d = stream0_data;
        end else if (stream1_last && stream1_ready) begin
            state_d = IDLE;
        end else if (state_q == SEND && stream1_ready) begin
            beat_d  = beat_q + BW'(1);
            shreg_d = MSB_FIRST ? shreg_q << OUT_WIDTH : shreg_q >> OUT_WIDTH;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            shreg_q <= shreg_d;
        end
    end
endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer: scoreboard bench driving an LSB-first and an MSB-first serializer
// with identical stimulus; each queue entry holds the expected beat of both.
module tb_stream_serializer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        s0_valid = 1'b0;
    logic        s1_ready = 1'b1;
    logic [31:0] s0_data = '0;
    logic        s0_ready_l, s1_valid_l, s1_last_l, busy_l;
    logic        s0_ready_m, s1_valid_m, s1_last_m, busy_m;
    logic [7:0]  s1_data_l, s1_data_m;

    stream_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset),
        .stream0_valid(s0_valid), .stream0_ready(s0_ready_l), .stream0_data(s0_data),
        .stream1_valid(s1_valid_l), .stream1_ready(s1_ready), .stream1_data(s1_data_l),
        .stream1_last(s1_last_l), .busy(busy_l)
    );

    stream_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset),
        .stream0_valid(s0_valid), .stream0_ready(s0_ready_m), .stream0_data(s0_data),
        .stream1_valid(s1_valid_m), .stream1_ready(s1_ready), .stream1_data(s1_data_m),
        .stream1_last(s1_last_m), .busy(busy_m)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    int          beats = 0;
    int          mode = 0;
    int          cyc = 0;
    logic [3:0]  pat = 4'b1001;
    logic [17:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready pattern: 0 always ready, 1 the 1,0,0,1 toggle, 2 random
    initial forever begin
        @(posedge clock);
        #1;
        cyc++;
        s1_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 4] : 1'($urandom_range(0, 1));
    end

    initial begin : monitor
        logic        prev_acc;
        logic        prev_stall;
        logic [8:0]  prev_out;
        logic [17:0] e;
        prev_acc = 1'b0;
        prev_stall = 1'b0;
        prev_out = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_acc = 1'b0;
                prev_stall = 1'b0;
            end else begin
                chk("s0_ready_rule", 32'(s0_ready_l), 32'(!s1_valid_l || (s1_ready && s1_last_l)));
                chk("twin_status", {s0_ready_m, s1_valid_m, busy_m, busy_l},
                    {s0_ready_l, s1_valid_l, s1_valid_m, s1_valid_l});
                if (prev_acc) chk("accept_latency", 32'(s1_valid_l), 32'd1);
                if (prev_stall) chk("hold_stable", {s1_valid_l, s1_last_l, s1_data_l}, {1'b1, prev_out});
                if (s1_valid_l && s1_ready) begin
                    beats++;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h expected none", s1_data_l);
                    end else begin
                        e = q.pop_front();
                        chk("beat_lsb", {s1_last_l, s1_data_l}, e[17:9]);
                        chk("beat_msb", {s1_last_m, s1_data_m}, e[8:0]);
                    end
                end
                prev_acc = s0_valid && s0_ready_l;
                prev_stall = s1_valid_l && !s1_ready;
                prev_out = {s1_last_l, s1_data_l};
            end
        end
    end

    // ls/ms list the expected beats in emission order, first beat in bits [31:24]
    task automatic send(input logic [31:0] w, input logic [31:0] ls, input logic [31:0] ms);
        int n = 0;
        logic ok = 1'b0;
        s0_valid = 1'b1;
        s0_data = w;
        while (!ok && n < 200) begin
            @(negedge clock);
            if (s0_ready_l) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
        end else begin
            for (int i = 0; i < 4; i++)
                q.push_back({1'(i == 3), ls[31-8*i -: 8], 1'(i == 3), ms[31-8*i -: 8]});
        end
        @(posedge clock);
        #1;
        s0_valid = 1'b0;
        s0_data = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin : stimulus
        int base;
        int n;
        logic [31:0] w;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", {s1_valid_l, s1_last_l, busy_l, s1_data_l, s1_data_m}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_s0_ready", 32'(s0_ready_l), 32'd1);
        @(posedge clock);
        #1;
        send(32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4);
        drain();
        send(32'h03020100, 32'h00010203, 32'h03020100);
        send(32'h07060504, 32'h04050607, 32'h07060504);
        drain();
        mode = 1;
        send(32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4);
        drain();
        mode = 0;
        base = beats;
        send(32'hA1B2C3D4, 32'hD4C3B2A1, 32'hA1B2C3D4);
        n = 0;
        while (beats < base + 2 && n < 50) begin
            @(posedge clock);
            n++;
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midword_reset", {s1_valid_l, s1_last_l, busy_l, s1_valid_m, s1_data_l, s1_data_m}, 32'd0);
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        send(32'h11223344, 32'h44332211, 32'h11223344);
        drain();
        mode = 2;
        repeat (1000) begin
            w = $urandom;
            send(w, {w[7:0], w[15:8], w[23:16], w[31:24]}, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
